// File: rtl/float_pkg.sv
// Shared definitions for the streaming float multiplier.
//   - float_class_t : 2-bit operand class {ZERO, NORMAL, INF, NAN}
//   - FLAG_*        : bit positions inside the optional 4-bit flag vector
//                     {invalid, overflow, underflow, inexact}
//   - helper functions giving field positions, bias, all-ones exponent and
//     the canonical quiet NaN for any MANTISSA_SIZE / EXPONENT_SIZE pair.
package float_pkg;

    typedef enum logic [1:0] {
        ZERO   = 2'd0,
        NORMAL = 2'd1,
        INF    = 2'd2,
        NAN    = 2'd3
    } float_class_t;

    localparam int FLAG_INEXACT   = 0;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_COUNT     = 4;

    function automatic int float_size(input int m, input int e);
        return 1 + e + m;
    endfunction

    function automatic int float_exp_lsb(input int m);
        return m;
    endfunction

    function automatic int float_sign_pos(input int m, input int e);
        return m + e;
    endfunction

    function automatic int float_bias(input int e);
        return (1 << (e - 1)) - 1;
    endfunction

    function automatic int float_exp_all_ones(input int e);
        return (1 << e) - 1;
    endfunction

    // Canonical quiet NaN: sign 0, exponent all ones, mantissa MSB only.
    // Returned right-aligned in 64 bits; callers truncate to their width.
    function automatic logic [63:0] float_qnan(input int m, input int e);
        return (((64'd1 << e) - 64'd1) << m) | (64'd1 << (m - 1));
    endfunction

endpackage

// File: rtl/float_round_rne.sv
// Normalize + round-to-nearest-even + exponent clamp for the normal path.
// Purely combinational; lives in the final pipeline stage.
// Ports:
//   prod     : (2*MANTISSA_SIZE+2)-bit product of hidden-bit mantissas
//   exp_in   : signed biased exponent sum (eA+eB-bias), EXPONENT_SIZE+2 bits
//   exp_out  : result exponent (all ones on overflow, 0 on underflow)
//   man_out  : result stored mantissa (0 on overflow/underflow)
//   overflow, underflow, inexact : status, only when FLOAT_MUL_STREAM_FLAGS_EN
//                                  is defined
module float_round_rne #(
    parameter int MANTISSA_SIZE = 23,
    parameter int EXPONENT_SIZE = 8
) (
    input  logic [2*MANTISSA_SIZE+1:0]      prod,
    input  logic signed [EXPONENT_SIZE+1:0] exp_in,
    output logic [EXPONENT_SIZE-1:0]        exp_out,
    output logic [MANTISSA_SIZE-1:0]        man_out
`ifdef FLOAT_MUL_STREAM_FLAGS_EN
    ,
    output logic                            overflow,
    output logic                            underflow,
    output logic                            inexact
`endif
);
    localparam int M  = MANTISSA_SIZE;
    localparam int E  = EXPONENT_SIZE;
    localparam int PW = 2 * M + 2;

    localparam logic signed [E+1:0] EXP_ZERO = '0;
    localparam logic signed [E+1:0] EXP_MAX  = {2'b00, {E{1'b1}}};

    logic          msb;
    logic [PW-1:0] norm;
    logic [M-1:0]  man_trunc;
    logic          guard_bit;
    logic          round_bit;
    logic          sticky_bit;
    logic          round_up;
    logic [M:0]    man_sum;
    logic          carry;
    logic signed [E+1:0] exp_fin;
    logic          ovf;
    logic          unf;

    // Product lies in [1,4): put the leading one at the top bit so the
    // mantissa/guard/round/sticky fields sit at fixed positions.
    assign msb  = prod[PW-1];
    assign norm = msb ? prod : (prod << 1);

    assign man_trunc  = norm[2*M:M+1];
    assign guard_bit  = norm[M];
    assign round_bit  = norm[M-1];
    assign sticky_bit = |norm[M-2:0];

    assign round_up = guard_bit && (round_bit || sticky_bit || man_trunc[0]);
    assign man_sum  = {1'b0, man_trunc} + {{M{1'b0}}, round_up};
    // A carry out leaves man_sum[M-1:0] all zero, which is the wanted mantissa.
    assign carry    = man_sum[M];

    assign exp_fin = exp_in + {{(E+1){1'b0}}, msb} + {{(E+1){1'b0}}, carry};

    assign unf = (exp_fin <= EXP_ZERO);
    assign ovf = !unf && (exp_fin >= EXP_MAX);

    assign exp_out = ovf ? {E{1'b1}} : (unf ? {E{1'b0}} : exp_fin[E-1:0]);
    assign man_out = (ovf || unf) ? {M{1'b0}} : man_sum[M-1:0];

`ifdef FLOAT_MUL_STREAM_FLAGS_EN
    assign overflow  = ovf;
    assign underflow = unf;
    assign inexact   = guard_bit || round_bit || sticky_bit || ovf || unf;
`endif

endmodule

// File: rtl/float_mul_stream.sv
// Pipelined IEEE-754-style float multiplier with a valid/ready stream
// interface, RNE rounding, flush-to-zero of subnormals and full
// zero/inf/NaN handling. A single global advance signal stalls every stage
// when the output is held by backpressure.
// Ports:
//   clk, resetn          : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (in_ready = !out_valid || out_ready)
//   in_a, in_b           : factors
//   out_valid / out_ready: product handshake
//   out_prod             : rounded product (registered)
//   out_flags            : {invalid, overflow, underflow, inexact}, present
//                          only when FLOAT_MUL_STREAM_FLAGS_EN is defined
// Stage layout (PIPE_STAGES = P):
//   P >= 3 : classify reg, multiply reg, P-3 delay regs, round/output reg
//   P == 2 : classify+multiply reg, round/output reg
module float_mul_stream
    import float_pkg::*;
#(
    parameter int MANTISSA_SIZE = 23,
    parameter int EXPONENT_SIZE = 8,
    parameter int PIPE_STAGES   = 3
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [EXPONENT_SIZE+MANTISSA_SIZE:0] in_a,
    input  logic [EXPONENT_SIZE+MANTISSA_SIZE:0] in_b,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [EXPONENT_SIZE+MANTISSA_SIZE:0] out_prod
`ifdef FLOAT_MUL_STREAM_FLAGS_EN
    ,
    output logic [FLAG_COUNT-1:0]              out_flags
`endif
);
    localparam int M   = MANTISSA_SIZE;
    localparam int E   = EXPONENT_SIZE;
    localparam int FS  = float_size(M, E);
    localparam int EW  = E + 2;
    localparam int SW  = M + 1;
    localparam int PW  = 2 * M + 2;
    localparam int S1W = 2 + 2 + 1 + EW + 2 * SW;
    localparam int MW  = 2 + 2 + 1 + EW + PW;
    // Number of registers holding the product before the output stage.
    localparam int CH  = (PIPE_STAGES > 2) ? PIPE_STAGES - 2 : 1;

    localparam logic [EW-1:0] BIAS_W   = EW'(float_bias(E));
    localparam logic [E-1:0]  EXP_ONES = E'(float_exp_all_ones(E));
    localparam logic [FS-1:0] QNAN     = FS'(float_qnan(M, E));

    logic adv;
    logic [PIPE_STAGES-1:0] v_q;

    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = v_q[PIPE_STAGES-1];

    // ------------------------------------------------------------------
    // Stage 1: unpack / classify
    // ------------------------------------------------------------------
    logic [FS-1:0]  op    [2];
    float_class_t   cls_c [2];
    logic [SW-1:0]  sig_c [2];
    logic [E-1:0]   exp_c [2];

    assign op[0] = in_a;
    assign op[1] = in_b;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            logic [M-1:0] man;
            assign man       = op[gi][M-1:0];
            assign exp_c[gi] = op[gi][float_exp_lsb(M)+E-1:float_exp_lsb(M)];

            // exp == 0 is zero regardless of mantissa: subnormals flush.
            always_comb begin
                cls_c[gi] = NORMAL;
                if (exp_c[gi] == '0)
                    cls_c[gi] = ZERO;
                else if (exp_c[gi] == EXP_ONES)
                    cls_c[gi] = (man == '0) ? INF : NAN;
            end

            // Hidden bit only for normals so zero operands multiply to zero.
            assign sig_c[gi] = {cls_c[gi] == NORMAL, man};
        end
    endgenerate

    logic          sign_c;
    logic [EW-1:0] exp_sum_c;
    logic [S1W-1:0] s1_c;
    logic [S1W-1:0] s1_data;

    assign sign_c    = in_a[float_sign_pos(M, E)] ^ in_b[float_sign_pos(M, E)];
    assign exp_sum_c = {2'b00, exp_c[0]} + {2'b00, exp_c[1]} - BIAS_W;
    assign s1_c      = {cls_c[0], cls_c[1], sign_c, exp_sum_c, sig_c[0], sig_c[1]};

    generate
        if (PIPE_STAGES > 2) begin : g_s1_reg
            logic [S1W-1:0] s1_q;
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn)
                    s1_q <= '0;
                else if (adv && in_valid)
                    s1_q <= s1_c;
            end
            assign s1_data = s1_q;
        end else begin : g_s1_merged
            assign s1_data = s1_c;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stage 2: multiply, then optional delay stages
    // ------------------------------------------------------------------
    logic [1:0]    s1_cls_a, s1_cls_b;
    logic          s1_sign;
    logic [EW-1:0] s1_exp;
    logic [SW-1:0] s1_sig_a, s1_sig_b;
    logic [PW-1:0] prod_c;
    logic [MW-1:0] m_c;
    logic          m0_src_valid;

    assign {s1_cls_a, s1_cls_b, s1_sign, s1_exp, s1_sig_a, s1_sig_b} = s1_data;
    assign prod_c = PW'(s1_sig_a) * PW'(s1_sig_b);
    assign m_c    = {s1_cls_a, s1_cls_b, s1_sign, s1_exp, prod_c};
    assign m0_src_valid = (PIPE_STAGES > 2) ? v_q[0] : in_valid;

    logic [CH-1:0][MW-1:0] m_q;

    // Registers only capture when their upstream stage holds valid data so
    // bubbles leave old contents in place.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v_q <= '0;
            m_q <= '0;
        end else if (adv) begin
            v_q <= {v_q[PIPE_STAGES-2:0], in_valid};
            if (m0_src_valid)
                m_q[0] <= m_c;
            for (int i = 1; i < CH; i++) begin
                if (v_q[i])
                    m_q[i] <= m_q[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Final stage: special-value selection, normalize/round, output reg
    // ------------------------------------------------------------------
    logic [1:0]    f_cls_a, f_cls_b;
    logic          f_sign;
    logic [EW-1:0] f_exp;
    logic [PW-1:0] f_prod;
    logic [E-1:0]  rnd_exp;
    logic [M-1:0]  rnd_man;
    logic          any_nan, any_inf, any_zero, invalid;
    logic [FS-1:0] prod_res;

    assign {f_cls_a, f_cls_b, f_sign, f_exp, f_prod} = m_q[CH-1];

`ifdef FLOAT_MUL_STREAM_FLAGS_EN
    logic rnd_ovf, rnd_unf, rnd_inexact;
    logic [FLAG_COUNT-1:0] flags_res;
`endif

    float_round_rne #(
        .MANTISSA_SIZE (M),
        .EXPONENT_SIZE (E)
    ) u_round (
        .prod      (f_prod),
        .exp_in    (f_exp),
        .exp_out   (rnd_exp),
        .man_out   (rnd_man)
`ifdef FLOAT_MUL_STREAM_FLAGS_EN
        ,
        .overflow  (rnd_ovf),
        .underflow (rnd_unf),
        .inexact   (rnd_inexact)
`endif
    );

    assign any_nan  = (f_cls_a == NAN)  || (f_cls_b == NAN);
    assign any_inf  = (f_cls_a == INF)  || (f_cls_b == INF);
    assign any_zero = (f_cls_a == ZERO) || (f_cls_b == ZERO);
    assign invalid  = any_nan || (any_inf && any_zero);

    always_comb begin
        prod_res = {f_sign, rnd_exp, rnd_man};
        if (invalid)
            prod_res = QNAN;
        else if (any_inf)
            prod_res = {f_sign, EXP_ONES, {M{1'b0}}};
        else if (any_zero)
            prod_res = {f_sign, {(FS-1){1'b0}}};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            out_prod <= '0;
        else if (adv && v_q[PIPE_STAGES-2])
            out_prod <= prod_res;
    end

`ifdef FLOAT_MUL_STREAM_FLAGS_EN
    // Overflow/underflow/inexact only make sense for the finite normal path.
    always_comb begin
        flags_res = '0;
        if (invalid) begin
            flags_res[FLAG_INVALID] = 1'b1;
        end else if (!any_inf && !any_zero) begin
            flags_res[FLAG_OVERFLOW]  = rnd_ovf;
            flags_res[FLAG_UNDERFLOW] = rnd_unf;
            flags_res[FLAG_INEXACT]   = rnd_inexact;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            out_flags <= '0;
        else if (adv && v_q[PIPE_STAGES-2])
            out_flags <= flags_res;
    end
`endif

endmodule
